// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
// Holds FSM states, requester ids and width defaults.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef enum logic {
    REQ_I,
    REQ_D
  } req_e;

  function automatic logic is_aligned(
    input logic [1:0] lsb
  );
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant, purely combinational.
// Bit 0 is fetch, bit 1 is data; ties go to the one not granted last.
import mem_arb_pkg::*;

module rr_arbiter2 (
  input  logic [1:0] req,
  input  req_e       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == REQ_D) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requesters onto one sync single-port RAM.
// One access per three cycles: IDLE accept, ACCESS drive RAM, RESP reply.
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_rsp_valid,
  output logic [DATA_W-1:0] i_rsp_data,
  output logic              i_rsp_err,

  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              d_rsp_err,

  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state;
  req_e              last_grant;
  req_e              owner;
  logic              lat_we;
  logic              lat_ok;
  logic [1:0]        grant;
  logic              idle;
  logic              hs_i;
  logic              hs_d;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ok;
  logic              rd_ok;

  rr_arbiter2 u_rr (
    .req        ({d_req_valid, i_req_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign idle        = (state == IDLE);
  assign i_req_ready = idle && grant[0];
  assign d_req_ready = idle && grant[1];
  assign hs_i        = i_req_valid && i_req_ready;
  assign hs_d        = d_req_valid && d_req_ready;
  assign req_addr    = hs_d ? d_req_addr : i_req_addr;
  assign req_ok      = is_aligned(req_addr[1:0]);

  // Read data arrives straight from the RAM in the RESP cycle.
  assign rd_ok      = !lat_we && lat_ok;
  assign i_rsp_data = (i_rsp_valid && rd_ok) ? mem_rdata : '0;
  assign d_rsp_data = (d_rsp_valid && rd_ok) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_grant  <= REQ_D;
      owner       <= REQ_I;
      lat_we      <= 1'b0;
      lat_ok      <= 1'b0;
      mem_w_en    <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      i_rsp_err   <= 1'b0;
      d_rsp_err   <= 1'b0;
    end else begin
      mem_w_en    <= 1'b0;
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      i_rsp_err   <= 1'b0;
      d_rsp_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hs_i || hs_d) begin
            state      <= ACCESS;
            owner      <= hs_d ? REQ_D : REQ_I;
            last_grant <= hs_d ? REQ_D : REQ_I;
            mem_addr   <= req_addr;
            mem_wdata  <= hs_d ? d_req_wdata : '0;
            lat_we     <= hs_d && d_req_we;
            lat_ok     <= req_ok;
            mem_w_en   <= hs_d && d_req_we && req_ok;
          end
        end
        ACCESS: begin
          state       <= RESP;
          i_rsp_valid <= (owner == REQ_I);
          d_rsp_valid <= (owner == REQ_D);
          i_rsp_err   <= (owner == REQ_I) && !lat_ok;
          d_rsp_err   <= (owner == REQ_D) && !lat_ok;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural sync RAM.
// Drives and samples on the falling edge.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req_valid;
  logic        i_req_ready;
  logic [31:0] i_req_addr;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_data;
  logic        i_rsp_err;
  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_req_we;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;
  logic        mem_w_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:63];

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .i_req_ready (i_req_ready),
    .i_req_addr  (i_req_addr),
    .i_rsp_valid (i_rsp_valid),
    .i_rsp_data  (i_rsp_data),
    .i_rsp_err   (i_rsp_err),
    .d_req_valid (d_req_valid),
    .d_req_ready (d_req_ready),
    .d_req_we    (d_req_we),
    .d_req_addr  (d_req_addr),
    .d_req_wdata (d_req_wdata),
    .d_rsp_valid (d_rsp_valid),
    .d_rsp_data  (d_rsp_data),
    .d_rsp_err   (d_rsp_err),
    .mem_w_en    (mem_w_en),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_w_en) ram[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:2]];
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic d_xfer(
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rdy,
    output logic        wen,
    output logic        v,
    output logic [31:0] data,
    output logic        err
  );
    int n;
    @(negedge clk);
    d_req_valid = 1'b1;
    d_req_we    = we;
    d_req_addr  = addr;
    d_req_wdata = wdata;
    #1;
    n = 0;
    while (!d_req_ready && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    rdy = d_req_ready;
    @(posedge clk);
    #1 d_req_valid = 1'b0;
    @(negedge clk);
    wen = mem_w_en;
    @(negedge clk);
    v    = d_rsp_valid;
    data = d_rsp_data;
    err  = d_rsp_err;
    @(negedge clk);
  endtask

  logic        rdy;
  logic        wen;
  logic        v;
  logic [31:0] data;
  logic        err;
  logic [1:0]  g [0:3];
  int          ng;

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'hA500_0000 | i;
    ram[4] = 32'hDEAD_BEEF;
    mem_rdata   = '0;
    rst         = 1'b0;
    i_req_valid = 1'b0;
    i_req_addr  = '0;
    d_req_valid = 1'b0;
    d_req_we    = 1'b0;
    d_req_addr  = '0;
    d_req_wdata = '0;

    repeat (2) @(negedge clk);
    chk("rst_wen", mem_w_en, 0);
    chk("rst_irsp", i_rsp_valid, 0);
    chk("rst_drsp", d_rsp_valid, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_ddata", d_rsp_data, 0);
    rst = 1'b1;

    // fetch from 0x10
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_addr  = 32'h10;
    #1;
    chk("f_irdy", i_req_ready, 1);
    chk("f_drdy", d_req_ready, 0);
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    @(negedge clk);
    chk("f_acc_rsp", i_rsp_valid, 0);
    chk("f_acc_rdy", i_req_ready, 0);
    chk("f_acc_wen", mem_w_en, 0);
    @(negedge clk);
    chk("f_rsp_v", i_rsp_valid, 1);
    chk("f_rsp_d", i_rsp_data, 32'hDEAD_BEEF);
    chk("f_rsp_e", i_rsp_err, 0);
    chk("f_drsp", d_rsp_valid, 0);
    @(negedge clk);
    chk("f_rsp_1cyc", i_rsp_valid, 0);

    // store then load 0x20
    @(negedge clk);
    d_req_valid = 1'b1;
    d_req_we    = 1'b1;
    d_req_addr  = 32'h20;
    d_req_wdata = 32'h1234_5678;
    #1;
    chk("st_rdy", d_req_ready, 1);
    @(posedge clk);
    #1 d_req_valid = 1'b0;
    @(negedge clk);
    chk("st_wen", mem_w_en, 1);
    chk("st_addr", mem_addr, 32'h20);
    chk("st_wdat", mem_wdata, 32'h1234_5678);
    @(negedge clk);
    chk("st_wen_off", mem_w_en, 0);
    chk("st_rsp_v", d_rsp_valid, 1);
    chk("st_rsp_d", d_rsp_data, 0);
    chk("st_rsp_e", d_rsp_err, 0);
    chk("st_irsp", i_rsp_valid, 0);
    chk("st_ram", ram[8], 32'h1234_5678);

    d_xfer(1'b0, 32'h20, 32'h0, rdy, wen, v, data, err);
    chk("ld_rdy", rdy, 1);
    chk("ld_wen", wen, 0);
    chk("ld_v", v, 1);
    chk("ld_d", data, 32'h1234_5678);
    chk("ld_e", err, 0);

    // misaligned store
    d_xfer(1'b1, 32'h22, 32'hFFFF_0000, rdy, wen, v, data, err);
    chk("mis_rdy", rdy, 1);
    chk("mis_wen", wen, 0);
    chk("mis_v", v, 1);
    chk("mis_d", data, 0);
    chk("mis_e", err, 1);
    chk("mis_ram", ram[8], 32'h1234_5678);

    // reset during a store ACCESS
    @(negedge clk);
    d_req_valid = 1'b1;
    d_req_we    = 1'b1;
    d_req_addr  = 32'h30;
    d_req_wdata = 32'hCAFE_F00D;
    #1;
    chk("ab_rdy", d_req_ready, 1);
    @(posedge clk);
    #1 d_req_valid = 1'b0;
    @(negedge clk);
    chk("ab_wen", mem_w_en, 1);
    rst = 1'b0;
    #1;
    chk("ab_wen_drop", mem_w_en, 0);
    @(negedge clk);
    chk("ab_rsp1", d_rsp_valid, 0);
    @(negedge clk);
    chk("ab_rsp2", d_rsp_valid, 0);
    chk("ab_ram", ram[12], 32'hA500_000C);
    rst = 1'b1;

    // both requesting from reset: I,D,I,D
    i_req_valid = 1'b1;
    i_req_addr  = 32'h4;
    d_req_valid = 1'b1;
    d_req_we    = 1'b0;
    d_req_addr  = 32'h8;
    #1;
    chk("tie_i", i_req_ready, 1);
    chk("tie_d", d_req_ready, 0);
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      chk("rr_excl", i_req_ready & d_req_ready, 0);
      if (i_req_ready) begin
        g[ng] = 2'd1;
        ng++;
      end else if (d_req_ready) begin
        g[ng] = 2'd2;
        ng++;
      end
    end
    chk("rr_count", ng, 4);
    chk("rr_g0", g[0], 1);
    chk("rr_g1", g[1], 2);
    chk("rr_g2", g[2], 1);
    chk("rr_g3", g[3], 2);
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
